// File: rtl/seg7_pkg.sv
// Shared types and segment encodings for the seven-segment scan driver.
// Segment patterns are active-low: bit 0 = a ... bit 6 = g.
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    // Codes 10..15 are not valid BCD and render as a dash.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
    };

    function automatic logic [6:0] seg_decode(input bcd_t digit);
        return SEG_LUT[digit];
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Digit data, control and display-pin bundle for seg7_scan_driver.
// The master drives digits/controls; the slave (the driver) drives seg/an.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 2
) ();

    logic [4*NUM_DIGITS-1:0] digit_in;
    logic                    load;
    logic                    blank_lz;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;

    modport master (
        output digit_in,
        output load,
        output blank_lz,
        input  seg,
        input  an
    );

    modport slave (
        input  digit_in,
        input  load,
        input  blank_lz,
        output seg,
        output an
    );

endinterface

// File: rtl/bcd_to_seg7.sv
// Purely combinational 4-bit code to active-low seven-segment pattern.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  bcd_t       i_bcd,
    output logic [6:0] o_seg
);

    assign o_seg = seg_decode(i_bcd);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with a load-strobed shadow
// register, one dead cycle per digit slot and optional leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int REFRESH_DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    seg7_scan_driver_if.slave   bus
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;

    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    bcd_t                    w_digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_zero_above;
    bcd_t                    w_sel_digit;
    logic [6:0]              w_dec_seg;
    logic                    w_blank;
    logic [6:0]              w_seg_nxt;
    logic [NUM_DIGITS-1:0]   w_an_nxt;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digits
        assign w_digits[g] = r_shadow[4*g +: 4];
    end

    always_comb begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        w_idx_nxt = r_idx;
        if (r_cnt == CNT_MAX) begin
            w_cnt_nxt = '0;
            w_idx_nxt = (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
        end
    end

    // w_zero_above[i]: digits i..NUM_DIGITS-1 of the shadow are all zero.
    always_comb begin
        w_zero_above = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_zero_above[i] = ((r_shadow >> (4 * i)) == '0);
        end
    end

    assign w_sel_digit = w_digits[w_idx_nxt];

    bcd_to_seg7 u_decode (
        .i_bcd (w_sel_digit),
        .o_seg (w_dec_seg)
    );

    assign w_blank = bus.blank_lz && (w_idx_nxt != '0) && w_zero_above[w_idx_nxt];

    // Outputs are registered from the upcoming slot position and the pre-load shadow.
    always_comb begin
        w_an_nxt  = '1;
        w_seg_nxt = SEG_OFF;
        if (w_cnt_nxt != '0) begin
            w_an_nxt[w_idx_nxt] = 1'b0;
            w_seg_nxt           = w_blank ? SEG_OFF : w_dec_seg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_an     <= '1;
            r_seg    <= SEG_OFF;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_idx <= w_idx_nxt;
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
            if (bus.load) begin
                r_shadow <= bus.digit_in;
            end
        end
    end

    assign bus.seg = r_seg;
    assign bus.an  = r_an;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed seven-segment driver that sits directly downstream of the cascaded BCD `counter` chain. It takes the chain's digit values, held as `NUM_DIGITS` packed 4-bit BCD digits, and captures them into a shadow register on a load strobe. It then scans them onto a common-anode display: it cycles through the digits, inserts one anti-ghosting dead cycle per slot, and optionally blanks leading zeros.

## Interface
- `NUM_DIGITS`, 2: number of digits scanned; ≥ 1.
- `REFRESH_DIV`, 4: clock cycles per digit slot; ≥ 2.
- `clk`  input  1: single clock; all state updates on its rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `digit_in`  input  4*NUM_DIGITS: packed BCD digits; [3:0] = digit 0 (least significant).
- `load`  input  1: when high at a rising edge, `digit_in` is copied into the shadow register.
- `blank_lz`  input  1: leading-zero blanking enable.
- `seg`  output  7: active-low segments; bit 0 = a … bit 6 = g.
- `an`  output  NUM_DIGITS: active-low digit enables, one-hot-low or all-high.

## Operation
- State:
  - `shadow` (4*NUM_DIGITS bits).
  - `cnt`, range 0..REFRESH_DIV-1.
  - `idx`, range 0..NUM_DIGITS-1.
  - Registered `seg` and `an`.
- Reset values: `shadow` = 0, `cnt` = 0, `idx` = 0, `an` = all 1, `seg` = 7'h7F.
- `cnt` increments every edge. When `cnt` = REFRESH_DIV-1 it wraps to 0 and `idx` advances; `idx` wraps from NUM_DIGITS-1 to 0.
- On each edge, `seg`/`an` are loaded from the *next* (`cnt`, `idx`):
  - Next `cnt` = 0 (dead cycle): `an` = all 1, `seg` = 7'h7F.
  - Otherwise: `an` = all 1 except bit `idx` = 0, and `seg` = decode of `shadow` digit `idx`.
- Decode (active-low):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10.
  - 10–15 display a dash, 7'h3F (only g lit).
- Blanking: digit i > 0 is blanked when `blank_lz` = 1 and shadow digits i..NUM_DIGITS-1 are all zero.
  - A blanked digit drives `seg` = 7'h7F while its `an` bit is still driven low.
  - Digit 0 is never blanked.
- `load`: `shadow` <= `digit_in` at the edge.
  - Outputs computed at that same edge use the old `shadow`. The new value is visible from the next edge.
  - `digit_in` changes without `load` have no effect.
- `blank_lz` is sampled directly at each edge when outputs are computed. It is not shadowed.

## Timing
- With no load, the output pattern is periodic with period NUM_DIGITS*REFRESH_DIV cycles. Each digit is lit for REFRESH_DIV-1 cycles, then there is 1 dead cycle.
- First edge after reset release: `cnt` = 1, `idx` = 0, so digit 0 is lit. The entry into digit 0 therefore has no extra dead cycle after reset.
- Load-to-display latency: 1 edge if the target digit is currently lit; otherwise it appears at that digit's next slot.
- Reset asserted mid-slot: outputs go to off values immediately, without waiting for a clock edge. The scan restarts at digit 0 after release; `shadow` is cleared.
- Simultaneous `load` and slot change: the slot change proceeds with the old `shadow`, and the new data is used from the next edge.

## Structure
- Package `seg7_pkg`:
  - Constants `SEG_OFF` = 7'h7F and `SEG_DASH` = 7'h3F.
  - 16-entry segment lookup table.
  - `typedef logic [3:0] bcd_t`.
- Sub-module `bcd_to_seg7`: purely combinational 4-bit → 7-bit decode using the package table.
- Top level: counters, shadow register, blanking logic and the output registers.

## Test plan
All scenarios use defaults (NUM_DIGITS=2, REFRESH_DIV=4).
- Reset held for 3 edges: `an` = 2'b11 and `seg` = 7'h7F throughout. After release, the `an` sequence is 10,10,10,11,01,01,01,11, repeating.
- `load` with `digit_in` = 8'h42, `blank_lz` = 0 -> `seg` = 7'h24 while `an` = 10, and 7'h19 while `an` = 01.
- `digit_in` = 8'h07 with `blank_lz` = 1 -> digit 1 slot shows `seg` = 7'h7F with `an` = 01; digit 0 shows 7'h78. With `blank_lz` = 0, digit 1 shows 7'h40. `digit_in` = 8'h00 with `blank_lz` = 1 -> digit 0 shows 7'h40.
- `digit_in` = 8'hA5 -> digit 1 shows 7'h3F (dash), digit 0 shows 7'h12.
- Load 8'h42, then change `digit_in` to 8'h99 with `load` = 0 for 16 cycles -> display unchanged. Pulse `load` during the digit 0 lit window -> 7'h10 appears on the next edge.
- Assert `reset` between clock edges during a lit slot -> `an` = 11 and `seg` = 7F before the next edge. After release, the scan restarts at digit 0 with `seg` = 7'h40.
